bus_mapper: RTL and testbench

Parametrised CPU-side memory-map controller between the core's byte bus and up to REGIONS on-chip devices (video RAM, font ROM, BIOS ROM, I/O). It decodes each access against per-region base/mask pairs, drives a one-hot device select for a per-region number of wait states, and registers read data. Unmapped reads return an open-bus value, and `ready` is a single-cycle completion strobe. It replaces the purely combinational single-region decode in the top level.

---
 rtl/bus_mapper.sv | 226 ++++++++++++++++++++++
 tb/tb_bus_mapper.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_mapper.sv
// ---------------------------------------------------------------------------
// bus_mapper
//
// Memory-map controller between the CPU byte bus and up to REGIONS on-chip
// devices. Each access is decoded against per-region base/mask pairs. The
// winning device is selected one-hot for 1 + W_i cycles. Read data is
// registered, and a one-cycle ready strobe marks completion. An access that
// hits no region reads back OPEN_BUS.
//
// Optional feature (macro BUS_MAPPER_TRAP_EN): records the first unmapped
// access address in trap_addr and raises trap_flag. The flag is cleared by
// trap_clr. Without the macro, trap_flag and trap_addr read as 0.
//
// Ports:
//   clock       in   sole clock, rising edge
//   reset       in   synchronous, active-high
//   req         in   access request strobe
//   address     in   CPU address            [ADDR_W]
//   out         in   CPU write data         [DATA_W]
//   wren        in   1 = write, 0 = read (sampled with req)
//   data        out  registered read data   [DATA_W]
//   ready       out  one-cycle completion strobe
//   dev_sel     out  one-hot device select  [REGIONS]
//   dev_addr    out  latched address        [ADDR_W]
//   dev_wdata   out  latched write data     [DATA_W]
//   dev_wren    out  device write enable (last access cycle only)
//   dev_rdata   in   packed device read data [REGIONS*DATA_W]
//   trap_flag   out  unmapped-access flag
//   trap_addr   out  first unmapped address [ADDR_W]
//   trap_clr    in   clears trap_flag
// ---------------------------------------------------------------------------
module bus_mapper #(
    parameter int                           ADDR_W      = 20,
    parameter int                           DATA_W      = 8,
    parameter int                           REGIONS     = 4,
    parameter logic [REGIONS*ADDR_W-1:0]    REGION_BASE = '0,
    parameter logic [REGIONS*ADDR_W-1:0]    REGION_MASK = '0,
    parameter logic [REGIONS*4-1:0]         REGION_WAIT = '0,
    parameter logic [DATA_W-1:0]            OPEN_BUS    = 8'hFF
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        req,
    input  logic [ADDR_W-1:0]           address,
    input  logic [DATA_W-1:0]           out,
    input  logic                        wren,
    output logic [DATA_W-1:0]           data,
    output logic                        ready,
    output logic [REGIONS-1:0]          dev_sel,
    output logic [ADDR_W-1:0]           dev_addr,
    output logic [DATA_W-1:0]           dev_wdata,
    output logic                        dev_wren,
    input  logic [REGIONS*DATA_W-1:0]   dev_rdata,
    output logic                        trap_flag,
    output logic [ADDR_W-1:0]           trap_addr,
    input  logic                        trap_clr
);

    localparam int IDX_W = (REGIONS > 1) ? $clog2(REGIONS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Address decode (combinational, from the live CPU address)
    // -----------------------------------------------------------------------
    logic [REGIONS-1:0]      hit_d;
    logic [DATA_W-1:0]       rdata_arr [REGIONS];
    logic [3:0]              wait_arr  [REGIONS];

    for (genvar gi = 0; gi < REGIONS; gi++) begin : g_region
        localparam logic [ADDR_W-1:0] BASE_I = REGION_BASE[gi*ADDR_W +: ADDR_W];
        localparam logic [ADDR_W-1:0] MASK_I = REGION_MASK[gi*ADDR_W +: ADDR_W];

        assign hit_d[gi]     = ((address & MASK_I) == (BASE_I & MASK_I));
        assign rdata_arr[gi] = dev_rdata[gi*DATA_W +: DATA_W];
        assign wait_arr[gi]  = REGION_WAIT[gi*4 +: 4];
    end

    // Priority encode: walk from the top so the lowest hitting index is the
    // last assignment and therefore wins.
    logic [IDX_W-1:0]   idx_d;
    logic               any_hit_d;
    logic [REGIONS-1:0] sel_d;
    logic [3:0]         wait_d;

    always_comb begin
        idx_d     = '0;
        any_hit_d = 1'b0;
        for (int i = REGIONS - 1; i >= 0; i--) begin
            if (hit_d[i]) begin
                idx_d     = IDX_W'(i);
                any_hit_d = 1'b1;
            end
        end
        sel_d  = '0;
        wait_d = 4'd0;
        // Unmapped accesses select nothing and complete with zero wait states.
        if (any_hit_d) begin
            sel_d[idx_d] = 1'b1;
            wait_d       = wait_arr[idx_d];
        end
    end

    // -----------------------------------------------------------------------
    // Access FSM with registered outputs
    // -----------------------------------------------------------------------
    state_t             state_q;
    logic [3:0]         cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               hit_q;
    logic               wr_q;
    logic [DATA_W-1:0]  data_q;
    logic               ready_q;
    logic [REGIONS-1:0] dev_sel_q;
    logic [ADDR_W-1:0]  dev_addr_q;
    logic [DATA_W-1:0]  dev_wdata_q;
    logic               dev_wren_q;
`ifdef BUS_MAPPER_TRAP_EN
    logic               trap_flag_q;
    logic [ADDR_W-1:0]  trap_addr_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            hit_q       <= 1'b0;
            wr_q        <= 1'b0;
            data_q      <= OPEN_BUS;
            ready_q     <= 1'b0;
            dev_sel_q   <= '0;
            dev_addr_q  <= '0;
            dev_wdata_q <= '0;
            dev_wren_q  <= 1'b0;
`ifdef BUS_MAPPER_TRAP_EN
            trap_flag_q <= 1'b0;
            trap_addr_q <= '0;
`endif
        end else begin
            // Strobes default low; each is raised for exactly one cycle below.
            ready_q    <= 1'b0;
            dev_wren_q <= 1'b0;

`ifdef BUS_MAPPER_TRAP_EN
            // A trap set later in this block overrides a coincident clear.
            if (trap_clr) begin
                trap_flag_q <= 1'b0;
            end
`endif

            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        dev_addr_q  <= address;
                        dev_wdata_q <= out;
                        wr_q        <= wren;
                        idx_q       <= idx_d;
                        hit_q       <= any_hit_d;
                        cnt_q       <= wait_d;
                        dev_sel_q   <= sel_d;
                        // With zero wait states the first ACCESS cycle is
                        // also the last, so the write enable starts now.
                        dev_wren_q  <= wren && (wait_d == 4'd0);
                        state_q     <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        if (!wr_q) begin
                            data_q <= hit_q ? rdata_arr[idx_q] : OPEN_BUS;
                        end
                        ready_q   <= 1'b1;
                        dev_sel_q <= '0;
`ifdef BUS_MAPPER_TRAP_EN
                        if (!hit_q) begin
                            trap_flag_q <= 1'b1;
                            if (!trap_flag_q) begin
                                trap_addr_q <= dev_addr_q;
                            end
                        end
`endif
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        // The next cycle is the last ACCESS cycle.
                        if (cnt_q == 4'd1) begin
                            dev_wren_q <= wr_q;
                        end
                    end
                end

                ST_ACK: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign ready     = ready_q;
    assign dev_sel   = dev_sel_q;
    assign dev_addr  = dev_addr_q;
    assign dev_wdata = dev_wdata_q;
    assign dev_wren  = dev_wren_q;

`ifdef BUS_MAPPER_TRAP_EN
    assign trap_flag = trap_flag_q;
    assign trap_addr = trap_addr_q;
`else
    logic unused_trap_clr;
    assign unused_trap_clr = trap_clr;
    assign trap_flag       = 1'b0;
    assign trap_addr       = '0;
`endif

endmodule

// File: tb/tb_bus_mapper.sv
module tb_bus_mapper;

    localparam int ADDR_W  = 20;
    localparam int DATA_W  = 8;
    localparam int REGIONS = 4;

`ifdef BUS_MAPPER_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      req;
    logic [ADDR_W-1:0]         address;
    logic [DATA_W-1:0]         out;
    logic                      wren;
    logic [DATA_W-1:0]         data;
    logic                      ready;
    logic [REGIONS-1:0]        dev_sel;
    logic [ADDR_W-1:0]         dev_addr;
    logic [DATA_W-1:0]         dev_wdata;
    logic                      dev_wren;
    logic [REGIONS*DATA_W-1:0] dev_rdata;
    logic                      trap_flag;
    logic [ADDR_W-1:0]         trap_addr;
    logic                      trap_clr;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Each device returns a fixed byte: region0 41, 1 52, 2 63, 3 74.
    assign dev_rdata = {8'h74, 8'h63, 8'h52, 8'h41};

    bus_mapper #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .REGIONS     (REGIONS),
        .REGION_BASE ({20'hA0000, 20'hB0000, 20'hC0000, 20'hB8000}),
        .REGION_MASK ({20'hF0000, 20'hF0000, 20'hFF000, 20'hFF000}),
        .REGION_WAIT ({4'd1, 4'd1, 4'd2, 4'd0}),
        .OPEN_BUS    (8'hFF)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .req       (req),
        .address   (address),
        .out       (out),
        .wren      (wren),
        .data      (data),
        .ready     (ready),
        .dev_sel   (dev_sel),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_wren  (dev_wren),
        .dev_rdata (dev_rdata),
        .trap_flag (trap_flag),
        .trap_addr (trap_addr),
        .trap_clr  (trap_clr)
    );

    typedef struct {
        logic [19:0] addr;
        logic [7:0]  wdata;
        logic        wr;
        logic [3:0]  sel;
        int          w;
        logic [7:0]  data;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one access at the next negedge and check it cycle by cycle.
    task automatic run_vec(input vec_t v, input int n);
        @(negedge clk);
        address = v.addr;
        out     = v.wdata;
        wren    = v.wr;
        req     = 1'b1;
        @(negedge clk);          // cycle 1
        req = 1'b0;
        for (int c = 1; c <= v.w + 1; c++) begin
            chk($sformatf("v%0d sel c%0d", n, c), 32'(dev_sel), 32'(v.sel));
            chk($sformatf("v%0d wren c%0d", n, c), 32'(dev_wren),
                32'(v.wr && (c == v.w + 1)));
            chk($sformatf("v%0d ready c%0d", n, c), 32'(ready), 32'd0);
            if (c == 1) begin
                chk($sformatf("v%0d dev_addr", n), 32'(dev_addr), 32'(v.addr));
                if (v.wr) chk($sformatf("v%0d dev_wdata", n), 32'(dev_wdata), 32'(v.wdata));
            end
            @(negedge clk);
        end
        // ACK cycle
        chk($sformatf("v%0d ready ack", n), 32'(ready), 32'd1);
        chk($sformatf("v%0d data", n), 32'(data), 32'(v.data));
        chk($sformatf("v%0d sel ack", n), 32'(dev_sel), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d ready after", n), 32'(ready), 32'd0);
        $display("[TB] txn %0d addr=%h wr=%0d sel=%b w=%0d data=%h", n, v.addr, v.wr, v.sel, v.w, data);
    endtask

    initial begin
        int   rdy_cnt;
        logic saw_sel0;
        vec_t v;

        vecs[0] = '{20'hB8123, 8'h00, 1'b0, 4'b0001, 0, 8'h41};
        vecs[1] = '{20'hC0010, 8'h5A, 1'b1, 4'b0010, 2, 8'h41};
        vecs[2] = '{20'h12345, 8'h00, 1'b0, 4'b0000, 0, 8'hFF};
        vecs[3] = '{20'hA0100, 8'h00, 1'b0, 4'b1000, 1, 8'h74};
        vecs[4] = '{20'hB4000, 8'h33, 1'b1, 4'b0100, 1, 8'h74};
        vecs[5] = '{20'hB8FFF, 8'h00, 1'b0, 4'b0001, 0, 8'h41};
        vecs[6] = '{20'hC0FFF, 8'h00, 1'b0, 4'b0010, 2, 8'h52};
        vecs[7] = '{20'hC1000, 8'h00, 1'b0, 4'b0000, 0, 8'hFF};
        vecs[8] = '{20'hB0000, 8'h00, 1'b0, 4'b0100, 1, 8'h63};

        reset = 1'b1; req = 1'b0; address = '0; out = '0; wren = 1'b0; trap_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst data", 32'(data), 32'hFF);
        chk("rst ready", 32'(ready), 32'd0);
        chk("rst sel", 32'(dev_sel), 32'd0);
        chk("rst wren", 32'(dev_wren), 32'd0);
        chk("rst dev_addr", 32'(dev_addr), 32'd0);
        chk("rst trap_flag", 32'(trap_flag), 32'd0);
        chk("rst trap_addr", 32'(trap_addr), 32'd0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Trap sequence: clear, first unmapped, second unmapped, clear.
        @(negedge clk); trap_clr = 1'b1;
        @(negedge clk); trap_clr = 1'b0;
        chk("trap clr0", 32'(trap_flag), 32'd0);
        v = '{20'h12345, 8'h00, 1'b0, 4'b0000, 0, 8'hFF};
        run_vec(v, 100);
        chk("trap flag1", 32'(trap_flag), 32'(TRAP));
        chk("trap addr1", 32'(trap_addr), TRAP ? 32'h12345 : 32'd0);
        v = '{20'h00010, 8'h00, 1'b0, 4'b0000, 0, 8'hFF};
        run_vec(v, 101);
        chk("trap addr2", 32'(trap_addr), TRAP ? 32'h12345 : 32'd0);
        @(negedge clk); trap_clr = 1'b1;
        @(negedge clk); trap_clr = 1'b0;
        chk("trap clr1", 32'(trap_flag), 32'd0);

        // req pulsed during ACCESS of a W=2 read is ignored: exactly one ready.
        @(negedge clk);
        address = 20'hC0020; wren = 1'b0; req = 1'b1;
        rdy_cnt = 0; saw_sel0 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (c == 2) begin address = 20'hB8000; req = 1'b1; end
            if (ready) rdy_cnt++;
            if (dev_sel[0]) saw_sel0 = 1'b1;
        end
        req = 1'b0;
        chk("ignored req ready count", 32'(rdy_cnt), 32'd1);
        chk("ignored req no sel0", 32'(saw_sel0), 32'd0);
        chk("ignored req data", 32'(data), 32'h52);
        $display("[TB] txn ignore-req readies=%0d data=%h", rdy_cnt, data);

        // Reset in the middle cycle of a W=2 write.
        @(negedge clk);
        address = 20'hC0010; out = 8'h77; wren = 1'b1; req = 1'b1;
        @(negedge clk); req = 1'b0;              // cycle 1
        chk("rstmid wren c1", 32'(dev_wren), 32'd0);
        @(negedge clk);                          // cycle 2
        chk("rstmid wren c2", 32'(dev_wren), 32'd0);
        chk("rstmid sel c2", 32'(dev_sel), 32'b0010);
        reset = 1'b1;
        @(negedge clk);                          // cycle 3
        reset = 1'b0;
        chk("rstmid wren c3", 32'(dev_wren), 32'd0);
        chk("rstmid sel c3", 32'(dev_sel), 32'd0);
        chk("rstmid ready c3", 32'(ready), 32'd0);
        chk("rstmid data c3", 32'(data), 32'hFF);
        chk("rstmid dev_addr c3", 32'(dev_addr), 32'd0);
        chk("rstmid dev_wdata c3", 32'(dev_wdata), 32'd0);
        chk("rstmid trap_flag c3", 32'(trap_flag), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstmid wren after", 32'(dev_wren), 32'd0);
            chk("rstmid ready after", 32'(ready), 32'd0);
        end
        $display("[TB] txn reset-mid-write done");
        wren = 1'b0;
        v = '{20'hB8010, 8'h00, 1'b0, 4'b0001, 0, 8'h41};
        run_vec(v, 200);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
